// File: rtl/xnor_match_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module   : xnor_match_accumulator_if
// Brief    : Equality-bit input stream and frame-result handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface xnor_match_accumulator_if #(
  parameter int CNT_W  = 4,
  parameter int GOOD_W = 8
);
  logic              in_valid;
  logic              eq_in;
  logic              in_ready;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  match_cnt;
  logic              frame_match;
  logic              all_equal;
  logic [GOOD_W-1:0] good_frames;

  modport master (
    output in_valid, eq_in, flush, out_ready,
    input  in_ready, out_valid, match_cnt, frame_match, all_equal, good_frames
  );

  modport slave (
    input  in_valid, eq_in, flush, out_ready,
    output in_ready, out_valid, match_cnt, frame_match, all_equal, good_frames
  );
endinterface
`default_nettype wire

// File: rtl/xnor_match_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : xnor_match_accumulator
// Brief    : Counts matching XNOR bits per frame; holds result until consumed.
// Revision : 1.0 - initial release
// ============================================================================
module xnor_match_accumulator #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4,
  parameter int THRESH    = 6,
  parameter int GOOD_W    = 8
) (
  input  wire                    clk,
  input  wire                    rst_n,
  xnor_match_accumulator_if.slave bus
);

  localparam int                c_idx_w     = $clog2(FRAME_LEN);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(FRAME_LEN - 1);
  localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
  localparam logic [CNT_W-1:0]  c_thresh    = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0]  c_full      = CNT_W'(FRAME_LEN);
  localparam logic [GOOD_W-1:0] c_good_max  = '1;
  localparam logic [GOOD_W-1:0] c_good_one  = GOOD_W'(1);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_acc;
  logic [c_idx_w-1:0] r_idx;
  logic [CNT_W-1:0]   r_match_cnt;
  logic               r_frame_match;
  logic               r_all_equal;
  logic [GOOD_W-1:0]  r_good;

  logic               w_accept;
  logic               w_last;
  logic               w_handshake;
  logic [CNT_W-1:0]   w_sum;

  assign w_sum = r_acc + {{(CNT_W-1){1'b0}}, bus.eq_in};
  assign w_last = (r_idx == c_idx_last);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        w_accept = bus.in_valid;
        // Flush wins over completion: the final bit is discarded with it.
        if (bus.in_valid && !bus.flush && w_last) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        w_handshake = bus.out_ready;
        if (bus.out_ready) begin
          w_state_nxt = ST_ACCUM;
        end
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_ACCUM;
      r_acc         <= '0;
      r_idx         <= '0;
      r_match_cnt   <= '0;
      r_frame_match <= 1'b0;
      r_all_equal   <= 1'b0;
      r_good        <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_ACCUM && bus.flush) begin
        r_acc <= '0;
        r_idx <= '0;
      end else if (w_accept) begin
        if (w_last) begin
          r_match_cnt   <= w_sum;
          r_frame_match <= (w_sum >= c_thresh);
          r_all_equal   <= (w_sum == c_full);
          r_acc         <= '0;
          r_idx         <= '0;
        end else begin
          r_acc <= w_sum;
          r_idx <= r_idx + c_idx_one;
        end
      end
      if (w_handshake && r_frame_match && (r_good != c_good_max)) begin
        r_good <= r_good + c_good_one;
      end
    end
  end

  assign bus.in_ready    = (r_state == ST_ACCUM);
  assign bus.out_valid   = (r_state == ST_HOLD);
  assign bus.match_cnt   = r_match_cnt;
  assign bus.frame_match = r_frame_match;
  assign bus.all_equal   = r_all_equal;
  assign bus.good_frames = r_good;

endmodule
`default_nettype wire

// File: tb/tb_xnor_match_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_xnor_match_accumulator
// Brief    : Directed plus random stimulus against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xnor_match_accumulator;
  localparam int FRAME_LEN = 8;
  localparam int CNT_W     = 4;
  localparam int THRESH    = 6;
  localparam int GOOD_W    = 2;
  localparam int GOOD_MAX  = (1 << GOOD_W) - 1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  xnor_match_accumulator_if #(.CNT_W(CNT_W), .GOOD_W(GOOD_W)) bus ();

  xnor_match_accumulator #(
    .FRAME_LEN(FRAME_LEN),
    .CNT_W    (CNT_W),
    .THRESH   (THRESH),
    .GOOD_W   (GOOD_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: bits of the current frame, pending result, good count.
  bit m_q[$];
  bit m_hold;
  int m_cnt;
  bit m_fm;
  bit m_ae;
  int m_good;

  // Compare at negedge, then advance using the inputs the next posedge will see.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_hold = 0;
      m_cnt  = 0;
      m_fm   = 0;
      m_ae   = 0;
      m_good = 0;
    end
    check("mdl_in_ready", bus.in_ready, !m_hold);
    check("mdl_out_valid", bus.out_valid, m_hold);
    check("mdl_good", bus.good_frames, m_good);
    if (m_hold) begin
      check("mdl_match_cnt", bus.match_cnt, m_cnt);
      check("mdl_frame_match", bus.frame_match, m_fm);
      check("mdl_all_equal", bus.all_equal, m_ae);
    end
    if (rst_n) begin
      if (m_hold) begin
        if (bus.out_ready) begin
          if (m_fm && m_good < GOOD_MAX) m_good++;
          m_hold = 0;
        end
      end else if (bus.flush) begin
        m_q.delete();
      end else if (bus.in_valid) begin
        m_q.push_back(bus.eq_in);
        if (m_q.size() == FRAME_LEN) begin
          m_cnt = 0;
          foreach (m_q[k]) m_cnt += m_q[k];
          m_fm = (m_cnt >= THRESH);
          m_ae = (m_cnt == FRAME_LEN);
          m_q.delete();
          m_hold = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input bit b, input bit fl);
    bus.in_valid = 1'b1;
    bus.eq_in    = b;
    bus.flush    = fl;
    tick();
    bus.in_valid = 1'b0;
    bus.eq_in    = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic feed_ones(input int n);
    for (int i = 0; i < n; i++) feed(1'b1, 1'b0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_match_cnt", bus.match_cnt, 0);
    check("rst_frame_match", bus.frame_match, 0);
    check("rst_all_equal", bus.all_equal, 0);
    check("rst_good", bus.good_frames, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bit [7:0] pat;
    n_checks      = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.eq_in     = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("init_in_ready", bus.in_ready, 1);
    check("init_good", bus.good_frames, 0);

    // Back-to-back frame 1,1,0,1,1,1,0,1
    bus.out_ready = 1'b1;
    pat = 8'b1101_1101;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (i == FRAME_LEN - 1) check("t2_early_valid", bus.out_valid, 0);
      feed(pat[7-i], 1'b0);
    end
    check("t2_out_valid", bus.out_valid, 1);
    check("t2_match_cnt", bus.match_cnt, 6);
    check("t2_frame_match", bus.frame_match, 1);
    check("t2_all_equal", bus.all_equal, 0);
    tick();
    check("t2_good", bus.good_frames, 1);
    check("t2_in_ready", bus.in_ready, 1);

    // Gapped frame 0,0,1,0,1,0,0,0 then backpressure
    bus.out_ready = 1'b0;
    pat = 8'b0010_1000;
    for (int i = 0; i < FRAME_LEN; i++) begin
      feed(pat[7-i], 1'b0);
      tick();
    end
    check("t3_match_cnt", bus.match_cnt, 2);
    check("t3_frame_match", bus.frame_match, 0);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.eq_in    = 1'b1;
      tick();
      check("t3_hold_valid", bus.out_valid, 1);
      check("t3_hold_ready", bus.in_ready, 0);
      check("t3_hold_cnt", bus.match_cnt, 2);
    end
    bus.in_valid  = 1'b0;
    bus.eq_in     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("t3_good", bus.good_frames, 1);

    // Flush after 3 zeros, then all ones
    for (int i = 0; i < 3; i++) feed(1'b0, 1'b0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    feed_ones(FRAME_LEN);
    check("t4_out_valid", bus.out_valid, 1);
    check("t4_match_cnt", bus.match_cnt, 8);
    check("t4_all_equal", bus.all_equal, 1);
    check("t4_frame_match", bus.frame_match, 1);
    tick();
    check("t4_good", bus.good_frames, 2);

    // Flush coincident with the final bit
    feed_ones(FRAME_LEN - 1);
    feed(1'b1, 1'b1);
    check("t5_no_valid", bus.out_valid, 0);
    pat = 8'b1010_1111;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (i == FRAME_LEN - 1) check("t5_early_valid", bus.out_valid, 0);
      feed(pat[7-i], 1'b0);
    end
    check("t5_out_valid", bus.out_valid, 1);
    check("t5_match_cnt", bus.match_cnt, 6);
    tick();
    check("t5_good", bus.good_frames, 3);

    // Reset while a result is pending
    bus.out_ready = 1'b0;
    feed_ones(FRAME_LEN);
    check("t1_pending", bus.out_valid, 1);
    async_reset();
    check("t1_in_ready", bus.in_ready, 1);
    check("t1_good", bus.good_frames, 0);

    // Saturation then mid-frame reset
    bus.out_ready = 1'b1;
    for (int f = 0; f < 5; f++) begin
      feed_ones(FRAME_LEN);
      tick();
    end
    check("t6_saturate", bus.good_frames, GOOD_MAX);
    feed_ones(4);
    async_reset();
    check("t6_good_cleared", bus.good_frames, 0);
    feed_ones(FRAME_LEN - 1);
    check("t6_early_valid", bus.out_valid, 0);
    feed_ones(1);
    check("t6_out_valid", bus.out_valid, 1);
    check("t6_match_cnt", bus.match_cnt, 8);
    tick();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.eq_in     = ($urandom_range(0, 99) < 70);
      bus.flush     = ($urandom_range(0, 24) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
